hilo_mult_unit: RTL
===================

// Module: hilo_mult_unit
// PURPOSE
//   Multi-cycle multiply/HI-LO unit sitting beside the ALU in EX, downstream of ALU control.
//   Executes ops steered to it by ALUOp 4'b1111: MULT, MULTU, MADD, MSUB, MUL.
//   Also executes MTHI and MTLO, and owns the HI/LO architectural registers read by MFHI/MFLO.
//   Iterative radix-2 shift-add core; the pipeline stalls EX while Busy=1.
// PARAMETERS
//   DATA_WIDTH  32  operand width; product is 2*DATA_WIDTH; iteration count = DATA_WIDTH
// PORTS
//   Clk     in   1   clock, rising edge
//   Reset   in   1   asynchronous, active-low reset
//   Start   in   1   request; sampled only in IDLE
//   ALUOp   in   4   from ALU control; 4'b1111 qualifies multiply ops
//   MulOp   in   3   000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MUL, 101 MTHI, 110 MTLO, 111 reserved
//   A       in   DW  rs operand (multiplicand, or MTHI/MTLO data)
//   B       in   DW  rt operand (multiplier)
//   Busy    out  1   high whenever state != IDLE
//   Done    out  1   one-cycle pulse when the op result is committed
//   Result  out  DW  MUL: low product word; other ops: new LO value; held until next Done
//   HiOut   out  DW  current HI register (MFHI source)
//   LoOut   out  DW  current LO register (MFLO source)
// BEHAVIOUR
//   Reset (Reset=0, async): state=IDLE, HI=LO=Result=0, Busy=0, Done=0, counter=0; any in-flight op aborts silently.
//   States:
//     IDLE:   accept Start per the rules below.
//     MULT:   performs DATA_WIDTH iterations.
//     FINISH: single commit cycle, then -> IDLE.
//   Accept rules in IDLE:
//     Start & ALUOp==1111 & MulOp<=100: at that edge, latch |A|, |B| (magnitudes for signed ops), neg_flag=A[msb]^B[msb] (0 for MULTU), op code;
//       clear 2*DW accumulator and counter; state->MULT.
//     Start & MulOp==101 (MTHI) / 110 (MTLO), any ALUOp: write HI / LO = A at that edge; Done=1 next cycle; Busy stays 0.
//     Start with MulOp==111, or with MulOp<=100 and ALUOp!=1111: ignored, no Done.
//   MULT: each edge, if multiplier LSB=1, add multiplicand into the product's upper half; shift right 1; counter++.
//     After DATA_WIDTH edges, state->FINISH.
//   FINISH edge:
//     p = neg_flag ? -prod : prod (mod 2^64).
//     MULT/MULTU: {HI,LO}=p. MADD: {HI,LO}+=p. MSUB: {HI,LO}-=p (all mod 2^(2*DW)).
//     MUL: Result=p[DW-1:0]; HI, LO unchanged. Other ops: Result=new LO.
//     Done<=1 (registered, high exactly one cycle); state->IDLE.
//   Latency: Start accepted at edge k -> HI/LO/Result/Done valid after edge k+DATA_WIDTH+1 (33 cycles at DW=32).
//   Busy is high from edge k to edge k+DATA_WIDTH+1.
//   Start while Busy=1: ignored; operands and op code are not re-latched.
//   Back-to-back: Start may be asserted in the Done cycle (state already IDLE) and is accepted.
//   HiOut/LoOut always reflect the committed registers; pre-commit values are visible until the FINISH edge.
//   MFHI/MFLO hazards are resolved by the stall on Busy.
//   A and B may change after the accept edge without effect.
// TESTING
//   MULTU A=FFFFFFFF B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001; Done exactly 33 cycles after accept; Busy high 33 cycles.
//   MULT A=FFFFFFFD(-3) B=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB, Result=FFFFFFEB.
//   MTHI 12345678; MTLO 00000009; MADD 2*3 -> HI=12345678, LO=0000000F; then MSUB 4*4 -> HI=12345677, LO=FFFFFFFF.
//   MUL A=00010000 B=00010000 -> Result=00000000, HI/LO unchanged; MUL A=FFFFFFFF B=2 -> Result=FFFFFFFE.
//   Reset low at iteration 10 of a MULT -> Busy=0, HI=LO=0 immediately, no Done; second Start at cycle 5 of a MULT is ignored.
//   Start with ALUOp=0010 MulOp=000 -> no Busy, no Done; new MULT issued in the Done cycle -> accepted, completes 33 cycles later.

Source files
------------

// File: rtl/hilo_mult_unit.sv
// Iterative radix-2 shift-add multiply unit that owns the HI/LO registers.
// Handles MULT/MULTU/MADD/MSUB/MUL over DATA_WIDTH cycles, and MTHI/MTLO in a single cycle.
module hilo_mult_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [3:0]            ALUOp,
  input  logic [2:0]            MulOp,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] HiOut,
  output logic [DATA_WIDTH-1:0] LoOut
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW) + 1;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_MULT   = 2'b01;
  localparam logic [1:0] ST_FINISH = 2'b10;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [1:0]      state_reg;
  logic [DW-1:0]   mcand_reg;
  logic [DW-1:0]   mplier_reg;
  logic [2*DW-1:0] prod_reg;
  logic [CW-1:0]   cnt_reg;
  logic            neg_reg;
  logic [2:0]      op_reg;
  logic [DW-1:0]   hi_reg;
  logic [DW-1:0]   lo_reg;
  logic [DW-1:0]   result_reg;
  logic            done_reg;

  logic            mult_accept;
  logic            is_signed;
  logic [DW-1:0]   a_mag;
  logic [DW-1:0]   b_mag;
  logic [DW:0]     step_sum;
  logic [2*DW-1:0] prod_signed;
  logic [2*DW-1:0] hilo_cur;
  logic [2*DW-1:0] hilo_next;

  assign mult_accept = Start && (ALUOp == 4'b1111) && (MulOp <= OP_MUL);
  assign is_signed   = (MulOp != OP_MULTU);
  // The core only multiplies magnitudes; the sign is reapplied at commit.
  assign a_mag = (is_signed && A[DW-1]) ? (~A + 1'b1) : A;
  assign b_mag = (is_signed && B[DW-1]) ? (~B + 1'b1) : B;

  // Add into the upper half with a carry bit, so the shift keeps all 2*DW bits.
  assign step_sum = {1'b0, prod_reg[2*DW-1:DW]} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);

  assign prod_signed = neg_reg ? (~prod_reg + 1'b1) : prod_reg;
  assign hilo_cur    = {hi_reg, lo_reg};

  always_comb begin
    hilo_next = prod_signed;
    case (op_reg)
      OP_MADD: hilo_next = hilo_cur + prod_signed;
      OP_MSUB: hilo_next = hilo_cur - prod_signed;
      default: hilo_next = prod_signed;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= ST_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      op_reg     <= OP_MULT;
      hi_reg     <= '0;
      lo_reg     <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mult_accept) begin
            mcand_reg  <= a_mag;
            mplier_reg <= b_mag;
            neg_reg    <= is_signed && (A[DW-1] ^ B[DW-1]);
            op_reg     <= MulOp;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            state_reg  <= ST_MULT;
          end else if (Start && (MulOp == OP_MTHI)) begin
            hi_reg     <= A;
            result_reg <= lo_reg;
            done_reg   <= 1'b1;
          end else if (Start && (MulOp == OP_MTLO)) begin
            lo_reg     <= A;
            result_reg <= A;
            done_reg   <= 1'b1;
          end
        end
        ST_MULT: begin
          prod_reg   <= {step_sum, prod_reg[DW-1:1]};
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(DW - 1)) begin
            state_reg <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (op_reg == OP_MUL) begin
            result_reg <= prod_signed[DW-1:0];
          end else begin
            hi_reg     <= hilo_next[2*DW-1:DW];
            lo_reg     <= hilo_next[DW-1:0];
            result_reg <= hilo_next[DW-1:0];
          end
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Busy   = (state_reg != ST_IDLE);
  assign Done   = done_reg;
  assign Result = result_reg;
  assign HiOut  = hi_reg;
  assign LoOut  = lo_reg;

endmodule
